dyn_decode_queue: RTL and testbench
===================================

Name: dyn_decode_queue

Overview:
- Parametrised successor to the single-register dynamic decode check.
- Sits between the static decoder (si_t) and rename/dispatch (di_t).
- Per-instruction work: assigns a wrapping instruction ID, evaluates privilege, trap and FPU-state faults against CSR flags, and classifies the fault cause.
- Results are held in a DEPTH-entry output queue with a valid/ready handshake and a flush input.

Parameters:
- ID_W, 20: width of the instruction ID counter; must be ≤ width of di_t.id, zero-extended into it.
- DEPTH, 2: output queue entries, legal range 1..4.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- flush_i  in  1  drop all queued entries.
- si_i  in  C::si_t  static-decoded instruction.
- si_i_valid  in  1  si_i valid.
- si_i_ready  out  1  queue can accept.
- fs_i  in  RV::xs_t  FPU state.
- priv_lvl_i  in  RV::priv_lvl_t  current privilege.
- frm_i  in  3  dynamic rounding mode.
- tvm_i, tw_i, tsr_i, debug_mode_i  in  1 each  trap and debug flags.
- di_o  out  C::di_t  head entry: si, id, fault, valid.
- di_o_cause  out  3  fault cause of the head entry.
- di_o_ready  in  1  consumer accepts head.

Behaviour:
- Reset (async on rst high):
  - Queue empty, count=0, ID counter=0.
  - di_o.valid=0, si_i_ready=1, di_o_cause=0.
  - di_o.si, di_o.id and di_o.fault read as 0.
- Push:
  - si_i_ready = (count < DEPTH). Registered count; no same-cycle pop bypass.
  - Push when si_i_valid && si_i_ready && !flush_i.
- Pop: when di_o.valid && di_o_ready.
- Simultaneous push and pop: count unchanged.
- Each entry is captured at the push cycle: si, id, fault, cause.
  - CSR inputs are sampled at that same cycle; later CSR changes do not alter queued entries.
- Latency: an instruction pushed at cycle N appears on di_o at N+1 at the earliest.
- Ordering: FIFO, pointers wrap mod DEPTH.
- ID counter:
  - Increments by 1 per push, wraps 2^ID_W-1 -> 0.
  - Not reset by flush, so IDs stay monotonic across flushes.
- Flush:
  - Empties the queue next cycle: count=0, di_o.valid=0.
  - Suppresses any same-cycle push and pop; the ID counter does not advance.
- di_o.fault = (cause != 0).
- Cause, first match wins:
  1. DRET && !debug_mode_i -> 3.
  2. MRET with priv != M; SRET, WFI or FENCE_VMA with priv == U -> 1.
  3. In S mode: SRET with tsr_i, WFI with tw_i, FENCE_VMA with tvm_i -> 2.
  4. fu == FU_FPU && fs_i == RV::Off -> 4.
  5. Rounding-mode fault (optional feature only) -> 5.
  6. Otherwise -> 0.
- Faulting instructions are queued and delivered normally; the block never blocks on a fault.
- Empty queue: di_o.valid=0, di_o_ready is ignored.
- Full queue: si_i_ready=0 even if di_o_ready=1 in the same cycle.

Optional Feature:
- Macro: DYN_DEC_FRM_CHECK_EN.
- When defined, the cause-5 check is active for FPU ops:
  - Fault if si_i.rm is in {5,6}.
  - Fault if si_i.rm == 7 and frm_i is in {5,6,7}.
- When undefined, rm and frm_i are ignored and cause 5 is never produced.

Test Plan:
- Reset, then push 3 ADDs back-to-back with di_o_ready=1 -> di_o at cycles 1..3 with id 0,1,2, fault=0, cause=0.
- DEPTH=2, di_o_ready=0, push 3 -> si_i_ready drops after 2 pushes. Raise di_o_ready -> pops id 0 then 1; third instr gets id 2.
- priv=U: MRET -> cause 1. priv=S, tsr_i=1: SRET -> cause 2. DRET with debug_mode_i=0 -> cause 3. All fault=1 and all still delivered.
- FU_FPU op with fs_i=Off -> cause 4. With fs_i=Initial -> cause 0. With the macro, rm=7 and frm_i=5 -> cause 5; without the macro -> cause 0.
- Two entries queued, then flush_i=1 with si_i_valid=1 -> next cycle di_o.valid=0, count 0, and the next pushed instr gets the ID following the last accepted one.
- ID_W=4, push 17 instrs -> IDs run 0..15, 0. Assert rst mid-stream -> di_o.valid=0 immediately (asynchronous), ID restarts at 0.

Source files
------------

// File: rtl/dyn_decode_queue.sv
// Dynamic decode check with a DEPTH-entry output queue between the static decoder and rename/dispatch.
// Latency: an instruction accepted at cycle N is visible on di_o at N+1 at the earliest.
// Backpressure: si_i_ready = (count < DEPTH) from the registered count; there is no same-cycle pop bypass.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush_i           drops every queued entry; suppresses any same-cycle push and pop
//   si_i/_valid/_ready static-decoded instruction input handshake
//   fs_i, priv_lvl_i, frm_i, tvm_i, tw_i, tsr_i, debug_mode_i   CSR state, sampled at the push cycle
//   di_o, di_o_cause, di_o_ready   queue head (si, id, fault, valid) with its fault cause
// Optional feature macro: DYN_DEC_FRM_CHECK_EN (rounding-mode fault, cause 5, for FPU ops).

package RV;
  typedef enum logic [1:0] {Off = 2'd0, Initial = 2'd1, Clean = 2'd2, Dirty = 2'd3} xs_t;
  typedef enum logic [1:0] {PRIV_LVL_U = 2'd0, PRIV_LVL_S = 2'd1, PRIV_LVL_M = 2'd3} priv_lvl_t;
endpackage

package C;
  typedef enum logic [2:0] {FU_NONE, FU_ALU, FU_BRANCH, FU_LSU, FU_FPU, FU_CSR} fu_t;
  typedef enum logic [3:0] {
    OP_ADD, OP_MRET, OP_SRET, OP_DRET, OP_WFI, OP_FENCE_VMA, OP_FADD, OP_CSRRW
  } op_t;
  typedef struct packed {
    logic [31:0] pc;
    fu_t         fu;
    op_t         op;
    logic [2:0]  rm;
  } si_t;
  typedef struct packed {
    si_t         si;
    logic [31:0] id;
    logic        fault;
    logic        valid;
  } di_t;
endpackage

module dyn_decode_queue #(
  parameter int ID_W  = 20,
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  C::si_t            si_i,
  input  logic              si_i_valid,
  output logic              si_i_ready,
  input  RV::xs_t           fs_i,
  input  RV::priv_lvl_t     priv_lvl_i,
  input  logic [2:0]        frm_i,
  input  logic              tvm_i,
  input  logic              tw_i,
  input  logic              tsr_i,
  input  logic              debug_mode_i,
  output C::di_t            di_o,
  output logic [2:0]        di_o_cause,
  input  logic              di_o_ready
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [ID_W-1:0] id_ctr;

  C::si_t          q_si    [DEPTH];
  logic [ID_W-1:0] q_id    [DEPTH];
  logic [2:0]      q_cause [DEPTH];

  logic       head_vld;
  logic       push;
  logic       pop;
  logic [2:0] cause_c;

  assign head_vld   = (count != '0);
  assign si_i_ready = (count < CW'(DEPTH));
  assign push       = si_i_valid && si_i_ready && !flush_i;
  assign pop        = head_vld && di_o_ready && !flush_i;

  // Pointers wrap mod DEPTH, which need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Fault classification; the first matching rule wins.
  always_comb begin
    cause_c = 3'd0;
    if (si_i.op == C::OP_DRET && !debug_mode_i) begin
      cause_c = 3'd3;
    end else if ((si_i.op == C::OP_MRET && priv_lvl_i != RV::PRIV_LVL_M) ||
                 ((si_i.op inside {C::OP_SRET, C::OP_WFI, C::OP_FENCE_VMA}) &&
                  priv_lvl_i == RV::PRIV_LVL_U)) begin
      cause_c = 3'd1;
    end else if (priv_lvl_i == RV::PRIV_LVL_S &&
                 ((si_i.op == C::OP_SRET && tsr_i) ||
                  (si_i.op == C::OP_WFI && tw_i) ||
                  (si_i.op == C::OP_FENCE_VMA && tvm_i))) begin
      cause_c = 3'd2;
    end else if (si_i.fu == C::FU_FPU && fs_i == RV::Off) begin
      cause_c = 3'd4;
`ifdef DYN_DEC_FRM_CHECK_EN
    end else if (si_i.fu == C::FU_FPU &&
                 ((si_i.rm inside {3'd5, 3'd6}) ||
                  (si_i.rm == 3'd7 && (frm_i inside {3'd5, 3'd6, 3'd7})))) begin
      cause_c = 3'd5;
`endif
    end
  end

`ifndef DYN_DEC_FRM_CHECK_EN
  // Rounding-mode inputs only matter when the rounding-mode check is built in.
  logic unused_frm;
  assign unused_frm = ^{frm_i, si_i.rm};
`endif

  // Control state: flush empties the queue but keeps the ID counter so IDs stay monotonic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      id_ctr <= '0;
    end else if (flush_i) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
        id_ctr <= id_ctr + ID_W'(1);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (!push && pop) begin
        count <= count - CW'(1);
      end
    end
  end

  // Payload storage; outputs are masked when empty so stale entries never need clearing.
  always_ff @(posedge clk) begin
    if (push) begin
      q_si[wr_ptr]    <= si_i;
      q_id[wr_ptr]    <= id_ctr;
      q_cause[wr_ptr] <= cause_c;
    end
  end

  always_comb begin
    di_o       = '0;
    di_o_cause = 3'd0;
    if (head_vld) begin
      di_o.si              = q_si[rd_ptr];
      di_o.id[ID_W-1:0]    = q_id[rd_ptr];
      di_o.fault           = (q_cause[rd_ptr] != 3'd0);
      di_o.valid           = 1'b1;
      di_o_cause           = q_cause[rd_ptr];
    end
  end

endmodule

// File: tb/tb_dyn_decode_queue.sv
module tb_dyn_decode_queue;

  localparam int DEPTH = 2;
  localparam int ID_W  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  C::si_t        si_i = '0;
  logic          si_i_valid = 1'b0;
  logic          si_i_ready;
  RV::xs_t       fs_i = RV::Dirty;
  RV::priv_lvl_t priv_lvl_i = RV::PRIV_LVL_M;
  logic [2:0]    frm_i = 3'd0;
  logic          tvm_i = 1'b0;
  logic          tw_i = 1'b0;
  logic          tsr_i = 1'b0;
  logic          debug_mode_i = 1'b0;
  C::di_t        di_o;
  logic [2:0]    di_o_cause;
  logic          di_o_ready = 1'b0;

  dyn_decode_queue #(.ID_W(ID_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .si_i(si_i), .si_i_valid(si_i_valid), .si_i_ready(si_i_ready),
    .fs_i(fs_i), .priv_lvl_i(priv_lvl_i), .frm_i(frm_i),
    .tvm_i(tvm_i), .tw_i(tw_i), .tsr_i(tsr_i), .debug_mode_i(debug_mode_i),
    .di_o(di_o), .di_o_cause(di_o_cause), .di_o_ready(di_o_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    C::si_t          si;
    logic [ID_W-1:0] id;
    int              cause;
  } exp_t;

  exp_t            exp_q[$];
  logic [ID_W-1:0] id_m = '0;
  int              acc_cnt = 0;
  int              dir_cause = -1;   // >= 0: directed expectation overrides the model
  int              tests = 0;
  int              fails = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference fault rules written directly from the priority list.
  function automatic int model_cause(input C::op_t op, input C::fu_t fu, input logic [2:0] rm,
                                     input logic [2:0] frm, input RV::priv_lvl_t p,
                                     input RV::xs_t fs, input logic tvm, input logic tw,
                                     input logic tsr, input logic dbg);
    bit is_u = (p == RV::PRIV_LVL_U);
    bit is_s = (p == RV::PRIV_LVL_S);
    if (op == C::OP_DRET && !dbg) return 3;
    if (op == C::OP_MRET && p != RV::PRIV_LVL_M) return 1;
    if (is_u && (op == C::OP_SRET || op == C::OP_WFI || op == C::OP_FENCE_VMA)) return 1;
    if (is_s && op == C::OP_SRET && tsr) return 2;
    if (is_s && op == C::OP_WFI && tw) return 2;
    if (is_s && op == C::OP_FENCE_VMA && tvm) return 2;
    if (fu == C::FU_FPU && fs == RV::Off) return 4;
`ifdef DYN_DEC_FRM_CHECK_EN
    if (fu == C::FU_FPU && (rm == 3'd5 || rm == 3'd6)) return 5;
    if (fu == C::FU_FPU && rm == 3'd7 && frm >= 3'd5) return 5;
`endif
    return 0;
  endfunction

  // Stimulus bookkeeping: decides acceptance from the model occupancy and records the expectation.
  initial begin : book
    exp_t e;
    logic acc;
    logic fl;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        id_m = '0;
      end else begin
        acc = si_i_valid && !flush_i && (exp_q.size() < DEPTH);
        fl  = flush_i;
        e.si = si_i;
        e.id = id_m;
        e.cause = (dir_cause >= 0) ? dir_cause :
                  model_cause(si_i.op, si_i.fu, si_i.rm, frm_i, priv_lvl_i, fs_i,
                              tvm_i, tw_i, tsr_i, debug_mode_i);
        #3;
        if (fl) begin
          exp_q.delete();
        end else if (acc) begin
          exp_q.push_back(e);
          id_m++;
          acc_cnt++;
        end
      end
    end
  end

  // Monitor: checks occupancy-derived handshakes and pops on every delivered head.
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        check("out_valid", 128'(di_o.valid), 128'(exp_q.size() != 0));
        check("in_ready", 128'(si_i_ready), 128'(exp_q.size() < DEPTH));
        if (exp_q.size() == 0) begin
          check("empty_fields", 128'({di_o.si, di_o.id, di_o.fault, di_o_cause}), 128'(0));
        end else if (di_o_ready && !flush_i) begin
          e = exp_q.pop_front();
          check("pop_entry", 128'({di_o.si, di_o.id, di_o.fault, di_o_cause}),
                128'({e.si, 32'(e.id), e.cause != 0, 3'(e.cause)}));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input C::op_t op, input C::fu_t fu, input logic [2:0] rm);
    si_i.op = op;
    si_i.fu = fu;
    si_i.rm = rm;
    si_i.pc = $urandom;
  endtask

  // Holds si_i_valid until the instruction is accepted; leaves valid low afterwards.
  task automatic push_wait();
    int start;
    bit ok;
    start = acc_cnt;
    ok = 0;
    si_i_valid = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      #4;
      if (acc_cnt != start) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL push_timeout: no acceptance within 30 cycles at %0t", $time);
    end
    tick();
    si_i_valid = 1'b0;
  endtask

  task automatic directed(input C::op_t op, input C::fu_t fu, input RV::priv_lvl_t p,
                          input int want);
    priv_lvl_i = p;
    dir_cause  = want;
    set_instr(op, fu, 3'd0);
    push_wait();
    dir_cause  = -1;
  endtask

  initial begin : main
    #2;
    check("reset_valid", 128'(di_o.valid), 128'(0));
    check("reset_ready", 128'(si_i_ready), 128'(1));
    check("reset_cause", 128'(di_o_cause), 128'(0));
    check("reset_fields", 128'({di_o.si, di_o.id, di_o.fault}), 128'(0));
    #10 rst = 1'b0;
    tick();

    // Three back-to-back ADDs with the consumer ready.
    di_o_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
      push_wait();
    end
    repeat (3) tick();

    // Fill the queue with the consumer stalled, then release it.
    di_o_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
      push_wait();
    end
    set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
    si_i_valid = 1'b1;
    repeat (3) tick();
    di_o_ready = 1'b1;
    push_wait();
    repeat (3) tick();

    // Directed fault causes with fixed expectations.
    directed(C::OP_MRET, C::FU_CSR, RV::PRIV_LVL_U, 1);
    tsr_i = 1'b1;
    directed(C::OP_SRET, C::FU_CSR, RV::PRIV_LVL_S, 2);
    tsr_i = 1'b0;
    tw_i = 1'b1;
    directed(C::OP_WFI, C::FU_CSR, RV::PRIV_LVL_S, 2);
    tw_i = 1'b0;
    directed(C::OP_FENCE_VMA, C::FU_CSR, RV::PRIV_LVL_U, 1);
    debug_mode_i = 1'b0;
    directed(C::OP_DRET, C::FU_CSR, RV::PRIV_LVL_M, 3);
    debug_mode_i = 1'b1;
    directed(C::OP_DRET, C::FU_CSR, RV::PRIV_LVL_M, 0);
    debug_mode_i = 1'b0;
    fs_i = RV::Off;
    directed(C::OP_FADD, C::FU_FPU, RV::PRIV_LVL_M, 4);
    fs_i = RV::Initial;
    directed(C::OP_FADD, C::FU_FPU, RV::PRIV_LVL_M, 0);
    fs_i = RV::Dirty;
    frm_i = 3'd5;
    priv_lvl_i = RV::PRIV_LVL_M;
`ifdef DYN_DEC_FRM_CHECK_EN
    dir_cause = 5;
`else
    dir_cause = 0;
`endif
    set_instr(C::OP_FADD, C::FU_FPU, 3'd7);
    push_wait();
    dir_cause = -1;
    frm_i = 3'd0;
    repeat (3) tick();

    // Flush with two entries queued and a push offered in the same cycle.
    di_o_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
      push_wait();
    end
    set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
    flush_i = 1'b1;
    si_i_valid = 1'b1;
    tick();
    flush_i = 1'b0;
    si_i_valid = 1'b0;
    tick();
    di_o_ready = 1'b1;
    set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
    push_wait();
    repeat (2) tick();

    // Randomized traffic against the reference model.
    for (int c = 0; c < 800; c++) begin
      si_i_valid   = ($urandom_range(0, 9) < 7);
      di_o_ready   = ($urandom_range(0, 9) < 7);
      flush_i      = ($urandom_range(0, 24) == 0);
      si_i.op      = C::op_t'(4'($urandom_range(0, 7)));
      case ($urandom_range(0, 2))
        0:       si_i.fu = C::FU_ALU;
        1:       si_i.fu = C::FU_FPU;
        default: si_i.fu = C::FU_CSR;
      endcase
      si_i.rm      = 3'($urandom_range(0, 7));
      si_i.pc      = $urandom;
      frm_i        = 3'($urandom_range(0, 7));
      fs_i         = RV::xs_t'(2'($urandom_range(0, 3)));
      case ($urandom_range(0, 2))
        0:       priv_lvl_i = RV::PRIV_LVL_U;
        1:       priv_lvl_i = RV::PRIV_LVL_S;
        default: priv_lvl_i = RV::PRIV_LVL_M;
      endcase
      tvm_i        = 1'($urandom_range(0, 1));
      tw_i         = 1'($urandom_range(0, 1));
      tsr_i        = 1'($urandom_range(0, 1));
      debug_mode_i = 1'($urandom_range(0, 1));
      tick();
    end
    si_i_valid = 1'b0;
    flush_i = 1'b0;
    di_o_ready = 1'b1;
    repeat (4) tick();

    // Asynchronous reset mid-stream with entries queued.
    di_o_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
      push_wait();
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("async_rst_valid", 128'(di_o.valid), 128'(0));
    check("async_rst_ready", 128'(si_i_ready), 128'(1));
    check("async_rst_id", 128'(di_o.id), 128'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Seventeen pushes after reset: IDs 0..15 then wrap to 0.
    di_o_ready = 1'b1;
    priv_lvl_i = RV::PRIV_LVL_M;
    fs_i = RV::Dirty;
    debug_mode_i = 1'b0;
    for (int i = 0; i < 17; i++) begin
      set_instr(C::OP_ADD, C::FU_ALU, 3'd0);
      push_wait();
    end
    repeat (6) tick();
    check("final_idle", 128'(di_o.valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
